// File: rtl/enc_2_in_pack.sv
// enc_2_in_pack: collects N serial elements into one packed enc_2 x vector.
// Optional ReLU on accept; vector held until the consumer acks it.
module enc_2_in_pack #(
  parameter int BITSIZE = 16,
  parameter int N       = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [BITSIZE-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 relu_en,
  output logic [BITSIZE*N-1:0] x,
  output logic                 x_valid,
  input  logic                 x_ack,
  output logic [2:0]           count
);

  typedef enum logic {
    FILL,
    FULL
  } state_e;

  state_e                state_q, state_d;
  logic [BITSIZE*N-1:0]  x_q, x_d;
  logic [2:0]            count_q, count_d;
  logic                  x_valid_q, x_valid_d;
  logic                  in_ready_q, in_ready_d;
  logic [BITSIZE-1:0]    elem;
  logic                  accept;

  assign elem   = (relu_en && in_data[BITSIZE-1]) ? '0 : in_data;
  assign accept = in_valid && in_ready_q && (state_q == FILL);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    count_d    = count_q;
    x_valid_d  = x_valid_q;
    in_ready_d = in_ready_q;
    if (clear) begin
      state_d    = FILL;
      x_d        = '0;
      count_d    = '0;
      x_valid_d  = 1'b0;
      in_ready_d = 1'b1;
    end else begin
      unique case (state_q)
        FILL: begin
          // ready rises on the first edge after reset release
          in_ready_d = 1'b1;
          if (accept) begin
            for (int i = 0; i < N; i++) begin
              if (count_q == 3'(i)) begin
                x_d[BITSIZE*(N-i)-1 -: BITSIZE] = elem;
              end
            end
            if (count_q == 3'(N-1)) begin
              state_d    = FULL;
              x_valid_d  = 1'b1;
              in_ready_d = 1'b0;
              count_d    = 3'(N);
            end else begin
              count_d = count_q + 3'd1;
            end
          end
        end
        FULL: begin
          if (x_ack) begin
            state_d    = FILL;
            x_valid_d  = 1'b0;
            in_ready_d = 1'b1;
            count_d    = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      x_q        <= '0;
      count_q    <= '0;
      x_valid_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      count_q    <= count_d;
      x_valid_q  <= x_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign x        = x_q;
  assign x_valid  = x_valid_q;
  assign in_ready = in_ready_q;
  assign count    = count_q;

endmodule

// File: tb/tb_enc_2_in_pack.sv
// Bench for enc_2_in_pack: directed scenarios plus random traffic
// against a slot-array reference model.
module tb_enc_2_in_pack;

  localparam int BITSIZE = 16;
  localparam int N       = 6;
  localparam int W       = BITSIZE * N;

  logic               clk;
  logic               reset;
  logic               clear;
  logic [BITSIZE-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               relu_en;
  logic [W-1:0]       x;
  logic               x_valid;
  logic               x_ack;
  logic [2:0]         count;

  int errors = 0;
  int checks = 0;

  bit                 m_full;
  bit                 m_ready;
  int                 m_cnt;
  logic [BITSIZE-1:0] slots [N];

  enc_2_in_pack #(.BITSIZE(BITSIZE), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .relu_en  (relu_en),
    .x        (x),
    .x_valid  (x_valid),
    .x_ack    (x_ack),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_x();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v = (v << BITSIZE) | W'(slots[k]);
    return v;
  endfunction

  task automatic model_rst();
    m_full  = 0;
    m_ready = 0;
    m_cnt   = 0;
    for (int k = 0; k < N; k++) slots[k] = '0;
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_rst();
    end else if (clear) begin
      m_full  = 0;
      m_cnt   = 0;
      m_ready = 1;
      for (int k = 0; k < N; k++) slots[k] = '0;
    end else if (!m_full) begin
      if (in_valid && m_ready) begin
        slots[m_cnt] = (relu_en && in_data[BITSIZE-1]) ? '0 : in_data;
        m_cnt++;
        if (m_cnt == N) m_full = 1;
      end
      m_ready = !m_full;
    end else if (x_ack) begin
      m_full  = 0;
      m_cnt   = 0;
      m_ready = 1;
    end
  endtask

  task automatic step(input logic v, input logic [BITSIZE-1:0] d,
                      input logic r, input logic a, input logic c);
    in_valid = v;
    in_data  = d;
    relu_en  = r;
    x_ack    = a;
    clear    = c;
    model_edge();
    @(posedge clk);
    #1;
    in_valid = 0;
    x_ack    = 0;
    clear    = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (x !== '0 || x_valid !== 0 || in_ready !== 0 || count !== 0) begin
      errors++;
      $display("FAIL reset_hold: x=%h v=%b r=%b c=%0d want all zero",
               x, x_valid, in_ready, count);
    end
    @(posedge clk);
    #1;
    reset = 1;
    step(0, '0, 0, 0, 0);
    checks++;
    if (in_ready !== 1 || count !== 0) begin
      errors++;
      $display("FAIL reset_release: ready=%b count=%0d want 1/0",
               in_ready, count);
    end
  endtask

  task automatic test_fill();
    logic [BITSIZE-1:0] d [N] = '{16'h0800, 16'h1000, 16'h0800,
                                  16'h1000, 16'h0800, 16'h1000};
    for (int k = 0; k < N; k++) begin
      checks++;
      if (count !== 3'(k) || x_valid !== 0 || in_ready !== 1) begin
        errors++;
        $display("FAIL fill_count[%0d]: count=%0d v=%b r=%b want %0d/0/1",
                 k, count, x_valid, in_ready, k);
      end
      step(1, d[k], 0, 0, 0);
    end
    checks++;
    if (x !== 96'h080010000800100008001000 || x_valid !== 1 ||
        in_ready !== 0 || count !== 6) begin
      errors++;
      $display("FAIL fill_full: x=%h v=%b r=%b c=%0d want 080010000800100008001000/1/0/6",
               x, x_valid, in_ready, count);
    end
    step(0, '0, 0, 1, 0);
    checks++;
    if (x_valid !== 0 || in_ready !== 1 || count !== 0) begin
      errors++;
      $display("FAIL fill_ack: v=%b r=%b c=%0d want 0/1/0",
               x_valid, in_ready, count);
    end
    step(1, 16'h7abc, 0, 0, 0);
    checks++;
    if (x !== 96'h7abc10000800100008001000 || count !== 1) begin
      errors++;
      $display("FAIL fill_retain: x=%h c=%0d want 7abc10000800100008001000/1",
               x, count);
    end
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_relu();
    logic [BITSIZE-1:0] d [N] = '{16'h0800, 16'h1000, 16'hF800,
                                  16'h1000, 16'h0800, 16'h0400};
    for (int k = 0; k < N; k++) step(1, d[k], 1, 0, 0);
    checks++;
    if (x !== 96'h080010000000100008000400 || x_valid !== 1) begin
      errors++;
      $display("FAIL relu_on: x=%h v=%b want 080010000000100008000400/1",
               x, x_valid);
    end
    step(0, '0, 0, 1, 0);
    for (int k = 0; k < N; k++) step(1, d[k], 0, 0, 0);
    checks++;
    if (x[63:48] !== 16'hF800 || x !== 96'h08001000F800100008000400) begin
      errors++;
      $display("FAIL relu_off: x=%h want 08001000f800100008000400", x);
    end
    step(0, '0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    for (int k = 0; k < N; k++) step(1, 16'($urandom), 1'($urandom), 0, 0);
    held = exp_x();
    for (int c = 0; c < 10; c++) begin
      step(1, 16'($urandom), 0, 0, 0);
      checks++;
      if (x !== held || count !== 6 || x_valid !== 1 || in_ready !== 0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: x=%h c=%0d v=%b r=%b want %h/6/1/0",
                 c, x, count, x_valid, in_ready, held);
      end
    end
    step(0, '0, 0, 1, 0);
    checks++;
    if (x_valid !== 0 || in_ready !== 1 || count !== 0 || x !== held) begin
      errors++;
      $display("FAIL bp_ack: v=%b r=%b c=%0d x=%h want 0/1/0/%h",
               x_valid, in_ready, count, x, held);
    end
  endtask

  task automatic test_gapped();
    bit pat [9]   = '{1, 0, 1, 1, 0, 0, 1, 1, 1};
    int exp_c [9] = '{1, 1, 2, 3, 3, 3, 4, 5, 6};
    for (int c = 0; c < 9; c++) begin
      step(pat[c], 16'($urandom), 0, 0, 0);
      checks++;
      if (count !== 3'(exp_c[c]) || x_valid !== (c == 8) || x !== exp_x()) begin
        errors++;
        $display("FAIL gap[%0d]: c=%0d v=%b x=%h want %0d/%b/%h",
                 c, count, x_valid, x, exp_c[c], (c == 8), exp_x());
      end
    end
    step(0, '0, 0, 1, 0);
  endtask

  task automatic test_interrupts();
    for (int k = 0; k < 3; k++) step(1, 16'($urandom) | 16'h0001, 0, 0, 0);
    step(1, 16'h1234, 0, 0, 1);
    checks++;
    if (count !== 0 || x !== '0 || in_ready !== 1 || x_valid !== 0) begin
      errors++;
      $display("FAIL clear_mid: c=%0d x=%h r=%b v=%b want 0/0/1/0",
               count, x, in_ready, x_valid);
    end
    for (int k = 0; k < N; k++) step(1, 16'($urandom) | 16'h0001, 0, 0, 0);
    step(0, '0, 0, 1, 1);
    checks++;
    if (count !== 0 || x !== '0 || in_ready !== 1 || x_valid !== 0) begin
      errors++;
      $display("FAIL clear_ack: c=%0d x=%h r=%b v=%b want 0/0/1/0",
               count, x, in_ready, x_valid);
    end
    for (int k = 0; k < 3; k++) step(1, 16'($urandom) | 16'h0001, 0, 0, 0);
    #2;
    reset = 0;
    model_rst();
    #1;
    checks++;
    if (count !== 0 || x !== '0 || in_ready !== 0 || x_valid !== 0) begin
      errors++;
      $display("FAIL async_rst: c=%0d x=%h r=%b v=%b want 0/0/0/0",
               count, x, in_ready, x_valid);
    end
    @(posedge clk);
    #1;
    reset = 1;
    step(0, '0, 0, 0, 0);
    checks++;
    if (in_ready !== 1 || count !== 0) begin
      errors++;
      $display("FAIL rst_release: r=%b c=%0d want 1/0", in_ready, count);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
      checks++;
      if (x !== exp_x() || x_valid !== m_full || in_ready !== m_ready ||
          count !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL rnd[%0d]: x=%h/%h v=%b/%b r=%b/%b c=%0d/%0d",
                 c, x, exp_x(), x_valid, m_full, in_ready, m_ready,
                 count, m_cnt);
      end
    end
  endtask

  initial begin
    reset    = 0;
    clear    = 0;
    in_data  = '0;
    in_valid = 0;
    relu_en  = 0;
    x_ack    = 0;
    model_rst();
    test_reset();
    test_fill();
    test_relu();
    test_backpressure();
    test_gapped();
    test_interrupts();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enc_2_in_pack.md
ENC_2_IN_PACK -- requirements
Module: enc_2_in_pack

Interface
REQ-001 The block SHALL have parameter BITSIZE, default 16: element width, signed fixed-point, 11 fractional bits (16'h0800 = 1.0, 16'h0400 = 0.5).
REQ-002 The block SHALL have parameter N, default 6: elements per packed vector, matching the enc_2 x input.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset; 0 resets all state immediately.
REQ-005 Port clear, input, 1: synchronous flush of a partially filled vector.
REQ-006 Port in_data, input, BITSIZE: one serial element from the upstream layer.
REQ-007 Port in_valid, input, 1: in_data is valid this cycle.
REQ-008 Port in_ready, output, 1: registered; the block accepts in_data this cycle.
REQ-009 Port relu_en, input, 1: apply ReLU to each element as it is accepted.
REQ-010 Port x, output, BITSIZE*N: packed vector for enc_2 x.
REQ-011 Port x_valid, output, 1: registered; x holds a complete vector.
REQ-012 Port x_ack, input, 1: the consumer has taken x.
REQ-013 Port count, output, 3: number of elements accepted into the current vector.

Function
REQ-014 The FSM SHALL have two states: FILL (collecting) and FULL (vector presented).
REQ-015 An element SHALL be accepted on a rising edge only when in_valid=1 and in_ready=1.
REQ-016 Element k (k = 0..N-1, arrival order) SHALL be written to x[BITSIZE*(N-k)-1 -: BITSIZE]; element 0 occupies the MS slice.
REQ-017 When relu_en=1 at acceptance and in_data[BITSIZE-1]=1, the stored slice SHALL be 0; otherwise in_data SHALL be stored unchanged.
REQ-018 In FILL, count SHALL increment by 1 on each acceptance.
REQ-019 On acceptance of element N-1, the same edge SHALL perform all of: go to FULL, set x_valid=1, set in_ready=0, set count=N.
REQ-020 In FULL, in_valid SHALL be ignored, and x and count SHALL remain stable.
REQ-021 In FULL, x_ack=1 on an edge SHALL do all of: go to FILL, set x_valid=0, set in_ready=1, set count=0. Acceptance of new input begins on the following edge.
REQ-022 x_ack SHALL be ignored in FILL.
REQ-023 Slices of x not yet rewritten in a new FILL pass SHALL keep their previous values.
REQ-024 clear=1 on an edge SHALL do all of: go to FILL, set count=0, set x to all zeros, set x_valid=0, set in_ready=1. clear has priority over acceptance and x_ack in the same cycle.
REQ-025 Latency SHALL be 1 edge from the last acceptance to x_valid=1.
REQ-026 Minimum period SHALL be N+1 cycles per vector: N acceptances plus 1 ack cycle.
REQ-027 No arithmetic beyond the ReLU sign test SHALL be performed; width is preserved with no saturation.

Reset
REQ-028 While reset=0, the block SHALL hold state=FILL, count=0, x=0, x_valid=0, in_ready=0.
REQ-029 On the first rising edge after reset returns to 1, in_ready SHALL become 1.
REQ-030 Reset asserted mid-fill or in FULL SHALL discard all contents immediately and asynchronously.

Verification
REQ-031 Reset: reset=0 at any time -> x=0, x_valid=0, in_ready=0, count=0 without waiting for a clock edge; release -> in_ready=1 after one edge.
REQ-032 Fill: relu_en=0; back-to-back 0800,1000,0800,1000,0800,1000 -> x_valid=1 one edge after the 6th element, x=96'h080010000800100008001000, in_ready=0, count=6.
REQ-033 ReLU: relu_en=1, elements 0800,1000,F800,1000,0800,0400 -> x=96'h080010000000100008000400; repeat with relu_en=0 -> slice 2 = F800.
REQ-034 Backpressure: after FULL, hold x_ack=0 and in_valid=1 for 10 cycles -> x unchanged and no acceptance; pulse x_ack -> next edge gives x_valid=0, in_ready=1, count=0.
REQ-035 Gapped input: in_valid pattern 1,0,1,1,0,0,1,1,1 -> count follows accepted elements only; x_valid rises after the 6th accepted element.
REQ-036 Interruptions, one fresh vector each case:
- clear=1 after 3 elements -> count=0, x=0.
- clear=1 together with x_ack in FULL -> clear result.
- async reset=0 mid-fill -> reset values immediately.
